// File: rtl/mem_access_s.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_s
// Brief    : Pipeline MEM stage with a word-addressed data RAM, configurable
//            access latency and a valid/ready handshake toward EX.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_s #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_memRead,
    input  logic        is_memWrite,
    input  logic [31:0] alu_data,
    input  logic [31:0] store_data,
    output logic        out_valid,
    output logic        out_is_memRead,
    output logic        out_is_memWrite,
    output logic [31:0] out_alu_data,
    output logic [31:0] mem_data
);

    localparam int c_aw          = $clog2(DEPTH);
    localparam int c_cw          = $clog2(LATENCY + 1);
    localparam int c_cnt_init    = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam bit c_single      = (LATENCY == 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_cw-1:0]     r_cnt;
    logic [31:0]         r_mem [DEPTH];

    logic                r_pend_rd;
    logic                r_pend_wr;
    logic [31:0]         r_pend_alu;
    logic [31:0]         r_pend_data;

    logic [c_aw-1:0]     w_index;
    logic                w_accept;
    logic                w_is_mem;
    logic [31:0]         w_data;

    assign w_index  = alu_data[c_aw+1:2];
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_is_mem = is_memRead || is_memWrite;

    // Stores take priority when both flags are set; the RAM read sees the
    // pre-edge contents, which never matters because a load is not a store.
    always_comb begin
        w_data = 32'd0;
        if (is_memWrite)
            w_data = store_data;
        else if (is_memRead)
            w_data = r_mem[w_index];
    end

    // RAM is intentionally not reset; a store commits at its acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept && is_memWrite)
            r_mem[w_index] <= store_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            out_valid       <= 1'b0;
            out_is_memRead  <= 1'b0;
            out_is_memWrite <= 1'b0;
            out_alu_data    <= 32'd0;
            mem_data        <= 32'd0;
            r_pend_rd       <= 1'b0;
            r_pend_wr       <= 1'b0;
            r_pend_alu      <= 32'd0;
            r_pend_data     <= 32'd0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem || c_single) begin
                            out_valid       <= 1'b1;
                            out_is_memRead  <= is_memRead;
                            out_is_memWrite <= is_memWrite;
                            out_alu_data    <= alu_data;
                            mem_data        <= w_data;
                        end else begin
                            r_pend_rd   <= is_memRead;
                            r_pend_wr   <= is_memWrite;
                            r_pend_alu  <= alu_data;
                            r_pend_data <= w_data;
                            r_cnt       <= c_cw'(c_cnt_init);
                            r_state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state         <= S_IDLE;
                        out_valid       <= 1'b1;
                        out_is_memRead  <= r_pend_rd;
                        out_is_memWrite <= r_pend_wr;
                        out_alu_data    <= r_pend_alu;
                        mem_data        <= r_pend_data;
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_s.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_s
// Brief    : Self-checking bench for mem_access_s at LATENCY 2, 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_s;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- LATENCY = 2 instance ----------------
    logic        rst, vld, rd, wr, rdy, ov, ord, owr;
    logic [31:0] alu, sd, oalu, md;

    mem_access_s #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(vld), .in_ready(rdy),
        .is_memRead(rd), .is_memWrite(wr), .alu_data(alu), .store_data(sd),
        .out_valid(ov), .out_is_memRead(ord), .out_is_memWrite(owr),
        .out_alu_data(oalu), .mem_data(md)
    );

    // ---------------- LATENCY = 4 instance ----------------
    logic        rst4, vld4, rd4, wr4, rdy4, ov4, ord4, owr4;
    logic [31:0] alu4, sd4, oalu4, md4;

    mem_access_s #(.DEPTH(256), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_valid(vld4), .in_ready(rdy4),
        .is_memRead(rd4), .is_memWrite(wr4), .alu_data(alu4), .store_data(sd4),
        .out_valid(ov4), .out_is_memRead(ord4), .out_is_memWrite(owr4),
        .out_alu_data(oalu4), .mem_data(md4)
    );

    // ---------------- LATENCY = 1 instance ----------------
    logic        rst1, vld1, rd1, wr1, rdy1, ov1, ord1, owr1;
    logic [31:0] alu1, sd1, oalu1, md1;

    mem_access_s #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(vld1), .in_ready(rdy1),
        .is_memRead(rd1), .is_memWrite(wr1), .alu_data(alu1), .store_data(sd1),
        .out_valid(ov1), .out_is_memRead(ord1), .out_is_memWrite(owr1),
        .out_alu_data(oalu1), .mem_data(md1)
    );

    // One record per cycle: inputs driven that cycle, outputs expected that cycle.
    typedef struct {
        logic        rst;
        logic        vld;
        logic        rd;
        logic        wr;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        e_rdy;
        logic        e_ov;
        logic        e_ord;
        logic        e_owr;
        logic [31:0] e_alu;
        logic [31:0] e_md;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst vld rd wr alu sd | rdy ov ord owr alu md
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,32'h10,32'h0,                1'b1,1'b0,1'b0,1'b0,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b1,1'b1,1'b0,1'b0,32'h10,32'h0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,32'h8,32'hDEADBEEF,          1'b1,1'b0,1'b0,1'b0,32'h10,32'h0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h8,32'h0,                 1'b0,1'b0,1'b0,1'b0,32'h10,32'h0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h8,32'h0,                 1'b1,1'b1,1'b0,1'b1,32'h8,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b0,1'b1,32'h8,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b1,1'b1,1'b1,1'b0,32'h8,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,32'h400,32'h12345678,        1'b1,1'b0,1'b1,1'b0,32'h8,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b1,1'b0,32'h8,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,32'h0,                 1'b1,1'b1,1'b0,1'b1,32'h400,32'h12345678});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h9,32'h0,                 1'b0,1'b0,1'b0,1'b1,32'h400,32'h12345678});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h9,32'h0,                 1'b1,1'b1,1'b1,1'b0,32'h0,32'h12345678});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b1,1'b0,32'h0,32'h12345678});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b1,1'b1,1'b1,1'b0,32'h9,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,32'hC,32'hCAFEF00D,          1'b1,1'b0,1'b1,1'b0,32'h9,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b1,1'b0,32'h9,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,32'h77,32'h0,                1'b1,1'b1,1'b1,1'b1,32'hC,32'hCAFEF00D});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,32'h99,32'h0,                1'b1,1'b1,1'b0,1'b0,32'h77,32'h0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'hC,32'h0,                 1'b1,1'b1,1'b0,1'b0,32'h99,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b0,1'b0,32'h99,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b1,1'b1,1'b1,1'b0,32'hC,32'hCAFEF00D});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b0,1'b0,1'b1,1'b0,32'hC,32'hCAFEF00D});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,                 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0});
    end

    initial begin
        logic        e_rd, e_wr;
        logic [31:0] e_alu, e_md;
        int          lat;
        int          pulses;

        rst = 1'b1;  vld = 1'b0;  rd = 1'b0;  wr = 1'b0;  alu = '0;  sd = '0;
        rst4 = 1'b1; vld4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0; alu4 = '0; sd4 = '0;
        rst1 = 1'b1; vld1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; alu1 = '0; sd1 = '0;
        repeat (2) @(posedge clk);

        // ---- LATENCY=2 table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; vld = vecs[i].vld; rd = vecs[i].rd;
            wr = vecs[i].wr;   alu = vecs[i].alu; sd = vecs[i].sd;
            #1;
            check($sformatf("v%0d in_ready", i),  {31'd0, rdy}, {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d out_valid", i), {31'd0, ov},  {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d out_rd", i),    {31'd0, ord}, {31'd0, vecs[i].e_ord});
            check($sformatf("v%0d out_wr", i),    {31'd0, owr}, {31'd0, vecs[i].e_owr});
            check($sformatf("v%0d out_alu", i),   oalu, vecs[i].e_alu);
            check($sformatf("v%0d mem_data", i),  md,   vecs[i].e_md);
        end

        // ---- LATENCY=4: reset during an in-flight store ----
        @(posedge clk); #1;
        rst4 = 1'b0; vld4 = 1'b1; wr4 = 1'b1; alu4 = 32'h4; sd4 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        vld4 = 1'b0; wr4 = 1'b0;
        check("l4 busy in_ready", {31'd0, rdy4}, 32'd0);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("l4 rst out_alu", oalu4, 32'h0);
        check("l4 rst out_wr", {31'd0, owr4}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (ov4) pulses++;
            @(posedge clk); #1;
        end
        check("l4 abandoned pulses", pulses, 0);
        check("l4 rst mem_data", md4, 32'h0);
        check("l4 idle in_ready", {31'd0, rdy4}, 32'd1);
        vld4 = 1'b1; rd4 = 1'b1; alu4 = 32'h4;
        @(posedge clk); #1;
        vld4 = 1'b0; rd4 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ov4) lat = k;
        end
        check("l4 load latency", lat, 3);
        check("l4 load mem_data", md4, 32'hA5A5A5A5);
        check("l4 load out_rd", {31'd0, ord4}, 32'd1);

        // ---- LATENCY=1: store then alternating load / non-mem every cycle ----
        @(posedge clk); #1;
        rst1 = 1'b0; vld1 = 1'b1; wr1 = 1'b1; rd1 = 1'b0; alu1 = 32'h10; sd1 = 32'h11223344;
        #1;
        check("l1 first in_ready", {31'd0, rdy1}, 32'd1);
        check("l1 first out_valid", {31'd0, ov1}, 32'd0);
        e_rd = 1'b0; e_wr = 1'b1; e_alu = 32'h10; e_md = 32'h11223344;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            wr1 = 1'b0;
            if (i % 2 == 1) begin
                rd1 = 1'b1; alu1 = 32'h10;
            end else begin
                rd1 = 1'b0; alu1 = 32'h100 + i;
            end
            #1;
            check($sformatf("l1 c%0d in_ready", i),  {31'd0, rdy1}, 32'd1);
            check($sformatf("l1 c%0d out_valid", i), {31'd0, ov1},  32'd1);
            check($sformatf("l1 c%0d out_rd", i),    {31'd0, ord1}, {31'd0, e_rd});
            check($sformatf("l1 c%0d out_wr", i),    {31'd0, owr1}, {31'd0, e_wr});
            check($sformatf("l1 c%0d out_alu", i),   oalu1, e_alu);
            check($sformatf("l1 c%0d mem_data", i),  md1,   e_md);
            e_rd = rd1; e_wr = 1'b0; e_alu = alu1;
            e_md = rd1 ? 32'h11223344 : 32'h0;
        end
        @(posedge clk); #1;
        vld1 = 1'b0; rd1 = 1'b0;
        #1;
        check("l1 last out_valid", {31'd0, ov1}, 32'd1);
        check("l1 last out_alu", oalu1, e_alu);
        @(posedge clk); #2;
        check("l1 drain out_valid", {31'd0, ov1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_s.md
Name: mem_access_s

Overview:
- Pipeline MEM stage. Produces the `mem_data`, `alu_data` and `is_memRead`/`is_memWrite` values the writeback mux consumes.
- Holds a word-addressed data RAM. Services loads and stores with a configurable access latency.
- Back-pressures the EX side with a valid/ready handshake while an access is in flight.
- Non-memory ops pass through registered in one cycle.

Parameters:
- DEPTH, 256, number of 32-bit words in data RAM (power of two, >=2).
- LATENCY, 2, cycles from acceptance of a memory op to out_valid (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  EX presents an op this cycle.
- in_ready  output  1  stage can accept an op this cycle.
- is_memRead  input  1  op is a load.
- is_memWrite  input  1  op is a store.
- alu_data  input  32  ALU result; used as byte address for memory ops.
- store_data  input  32  data to store.
- out_valid  output  1  one-cycle pulse; output fields valid.
- out_is_memRead  output  1  registered copy of is_memRead.
- out_is_memWrite  output  1  registered copy of is_memWrite.
- out_alu_data  output  32  registered copy of alu_data.
- mem_data  output  32  load result, or stored value for stores.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, counter=0, out_valid=0, all out_* fields=0, mem_data=0. RAM contents are NOT cleared.
- Handshake:
  - in_ready = (state==IDLE) && !rst.
  - An op transfers on an edge where in_valid && in_ready.
  - Inputs are ignored when in_ready=0; EX holds them.
- Index: alu_data[log2(DEPTH)+1:2].
  - Bits [1:0] are ignored (no misalignment trap).
  - Higher bits are truncated, so the address wraps modulo DEPTH words.
- Non-memory op (both flags 0) accepted at edge T:
  - Fields registered; out_valid=1 during cycle T+1; mem_data=0.
  - State stays IDLE, so back-to-back ops are accepted every cycle.
- Memory op accepted at edge T:
  - Store: RAM[index] <= store_data at edge T.
  - Load: RAM[index] sampled at edge T into a data hold register.
  - If both flags are set, the op is treated as a store. mem_data=store_data, and both out flags are copied as given.
  - If LATENCY==1: out_valid during cycle T+1 and state stays IDLE (identical timing to a non-memory op).
  - If LATENCY>1: state->BUSY and counter=LATENCY-2. Each BUSY edge decrements the counter. At the edge where the counter is 0: state->IDLE, out_valid=1 and fields updated.
  - Net effect: out_valid during cycle T+LATENCY, and in_ready=0 during cycles T+1 .. T+LATENCY-1.
- out_valid:
  - Asserted exactly one cycle per accepted op; no downstream stall.
  - Output fields hold their last values while out_valid=0.
- Ordering:
  - A load accepted after a store to the same index returns the new data, because the store commits at its acceptance edge.
  - A store and a load are never in flight together.
- Reset mid-operation:
  - The in-flight op is abandoned and no out_valid is produced.
  - A store already committed at acceptance remains in RAM.
- States: IDLE (accept), BUSY (count). No other states. An illegal encoding returns to IDLE.

Test Plan:
- Reset then non-mem op alu_data=0x0000_0010 at T -> out_valid only in T+1, out_alu_data=0x10, mem_data=0, in_ready stays 1.
- Store 0xDEAD_BEEF to addr 0x8, then load addr 0x8 (LATENCY=2) -> store out_valid at T+2 with mem_data=0xDEADBEEF; in_ready=0 at T+1; load returns 0xDEADBEEF two cycles after its acceptance.
- Wrap: DEPTH=256, store 0x1234_5678 at addr 0x400, load addr 0x0 -> mem_data=0x12345678. Load addr 0x9 reads RAM[2].
- in_valid held high with a load while BUSY -> not accepted until in_ready=1; exactly one out_valid per accepted op.
- rst asserted at T+1 during a LATENCY=4 store to addr 0x4 of 0xA5A5_A5A5 -> no out_valid; outputs zeroed; subsequent load addr 0x4 returns 0xA5A5A5A5.
- LATENCY=1 build: alternating load/non-mem ops every cycle -> out_valid high every cycle, in_ready never deasserts.
